// File: rtl/sram_arbiter_pkg.sv
// Shared types for the inst/data SRAM port arbiter.
// FSM phases, owner encoding and default widths.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between fetch and data.
// One transaction in flight; data wins unless fetch is starved.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e              state_q,  state_d;
    owner_e              owner_q,  owner_d;
    logic [CNT_W-1:0]    streak_q, streak_d;
    logic                wr_q,     wr_d;
    logic [STRB_W-1:0]   wstrb_q,  wstrb_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                grant_data;
    logic                grant_inst;

    // Data first, unless fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state_q == IDLE) begin
            grant_data = data_req && !(inst_req && streak_q == LIMIT);
            grant_inst = !grant_data && inst_req;
        end
    end

    // FSM state register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant -> address phase -> response phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_data || grant_inst) state_d = ADDR;
            ADDR:    if (mem_addr_ok) state_d = RESP;
            RESP:    if (mem_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the granted request and track the data-over-fetch streak.
    always_comb begin
        owner_d  = owner_q;
        streak_d = streak_q;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (grant_data) begin
            owner_d = OWN_DATA;
            wr_d    = data_wr;
            wstrb_d = data_wstrb;
            addr_d  = data_addr;
            wdata_d = data_wdata;
            if (!inst_req) begin
                streak_d = '0;
            end else if (streak_q != LIMIT) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (grant_inst) begin
            owner_d  = OWN_INST;
            wr_d     = 1'b0;
            wstrb_d  = '0;
            addr_d   = inst_addr;
            wdata_d  = '0;
            streak_d = '0;
        end
    end

    // Latched request fields and arbitration history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= OWN_INST;
            streak_q <= '0;
            wr_q     <= 1'b0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Handshake outputs; the response goes only to the owner.
    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        mem_req      = (state_q == ADDR);
        inst_data_ok = (state_q == RESP) && mem_data_ok
                       && (owner_q == OWN_INST);
        data_data_ok = (state_q == RESP) && mem_data_ok
                       && (owner_q == OWN_DATA);
    end

    assign mem_wr     = wr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter.
// Random traffic against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [SW-1:0] data_wstrb = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req;
    logic          mem_wr;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok = 1'b0;
    logic          mem_data_ok = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: one pending transaction and a streak count.
    bit            busy, accepted, fast;
    bit            t_data, t_wr;
    logic [SW-1:0] t_wstrb;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    int            streak;
    bit            g_data, g_inst;
    byte           glog[$];

    task automatic chk_eq(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // mode: 0 random, 1 both high, 2 fixed fetch, 3 none, 4 fixed write
    task automatic drive(int mode);
        inst_req   = ($urandom % 3) != 0;
        data_req   = ($urandom % 2) == 1;
        inst_addr  = $urandom;
        data_wr    = $urandom % 2;
        data_wstrb = SW'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        mem_rdata  = $urandom;
        if (mode == 1) begin
            inst_req = 1'b1;
            data_req = 1'b1;
        end else if (mode == 2) begin
            inst_req  = 1'b1;
            data_req  = 1'b0;
            inst_addr = 32'h1c00_0000;
        end else if (mode == 3) begin
            inst_req = 1'b0;
            data_req = 1'b0;
        end else if (mode == 4) begin
            inst_req   = 1'b0;
            data_req   = 1'b1;
            data_wr    = 1'b1;
            data_wstrb = 4'hF;
            data_addr  = 32'h100;
            data_wdata = 32'hDEAD_BEEF;
        end
        if (mode == 2 || mode == 3) mem_rdata = 32'h0280_0000;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (busy && !accepted) begin
            mem_addr_ok = fast || (($urandom % 3) == 0);
            mem_data_ok = !fast && (($urandom % 4) == 0);
        end else if (busy) begin
            mem_data_ok = fast || (($urandom % 2) == 0);
        end
    endtask

    task automatic check_cycle();
        bit ei, ed;
        g_data = !busy && data_req && !(inst_req && streak == SL);
        g_inst = !busy && !g_data && inst_req;
        chk_eq("inst_addr_ok", 64'(inst_addr_ok), 64'(g_inst));
        chk_eq("data_addr_ok", 64'(data_addr_ok), 64'(g_data));
        chk_eq("mem_req", 64'(mem_req), 64'(busy && !accepted));
        if (busy && !accepted) begin
            chk_eq("mem_wr", 64'(mem_wr), 64'(t_wr));
            chk_eq("mem_addr", 64'(mem_addr), 64'(t_addr));
            chk_eq("mem_wstrb", 64'(mem_wstrb), 64'(t_wstrb));
            if (t_wr) chk_eq("mem_wdata", 64'(mem_wdata), 64'(t_wdata));
        end
        ei = busy && accepted && mem_data_ok && !t_data;
        ed = busy && accepted && mem_data_ok && t_data;
        chk_eq("inst_data_ok", 64'(inst_data_ok), 64'(ei));
        chk_eq("data_data_ok", 64'(data_data_ok), 64'(ed));
        if (ei) chk_eq("inst_rdata", 64'(inst_rdata), 64'(mem_rdata));
        if (ed && !t_wr) chk_eq("data_rdata", 64'(data_rdata), 64'(mem_rdata));
        if (data_addr_ok) glog.push_back("D");
        else if (inst_addr_ok) glog.push_back("I");
    endtask

    task automatic update();
        if (g_data || g_inst) begin
            busy     = 1'b1;
            accepted = 1'b0;
            t_data   = g_data;
            t_wr     = g_data ? data_wr : 1'b0;
            t_wstrb  = g_data ? data_wstrb : '0;
            t_addr   = g_data ? data_addr : inst_addr;
            t_wdata  = g_data ? data_wdata : '0;
            if (g_data && inst_req) streak = (streak < SL) ? streak + 1 : SL;
            else streak = 0;
        end else if (busy && !accepted) begin
            if (mem_addr_ok) accepted = 1'b1;
        end else if (busy && mem_data_ok) begin
            busy = 1'b0;
        end
    endtask

    task automatic cycle(int mode);
        @(negedge clk);
        drive(mode);
        #1;
        check_cycle();
        @(posedge clk);
        update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk_eq("rst_mem_req", 64'(mem_req), 64'(0));
        chk_eq("rst_mem_wr", 64'(mem_wr), 64'(0));
        chk_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk_eq("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
        chk_eq("rst_inst_data_ok", 64'(inst_data_ok), 64'(0));
        chk_eq("rst_data_data_ok", 64'(data_data_ok), 64'(0));
        busy     = 1'b0;
        accepted = 1'b0;
        streak   = 0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        string exp_seq;
        byte   ch;
        int    n;
        fast = 1'b1;
        do_reset();

        // Single fetch with the fastest memory.
        cycle(2);
        cycle(3);
        cycle(3);
        cycle(3);

        // Stalled write; requester drops its fields after addr_ok.
        fast = 1'b0;
        cycle(4);
        for (int i = 0; i < 20; i++) cycle(3);

        // Both requesting forever: fetch forced every fifth grant.
        do_reset();
        fast = 1'b1;
        glog.delete();
        for (int i = 0; i < 40; i++) cycle(1);
        exp_seq = "DDDDIDDDDI";
        chk_eq("grant_count_ge10", 64'(glog.size() >= 10), 64'(1));
        n = (glog.size() < 10) ? glog.size() : 10;
        for (int i = 0; i < n; i++) begin
            ch = exp_seq[i];
            chk_eq($sformatf("grant_seq%0d", i), 64'(glog[i]), 64'(ch));
        end

        // Random traffic with random memory timing.
        fast = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) fast = ($urandom % 4) == 0;
            cycle(0);
        end

        // Reset while a response is outstanding.
        fast = 1'b0;
        n = 0;
        while (!(busy && accepted) && n < 200) begin
            cycle(0);
            n++;
        end
        chk_eq("reached_resp", 64'(busy && accepted), 64'(1));
        do_reset();
        cycle(2);
        chk_eq("post_rst_inst_grant", 64'(inst_addr_ok), 64'(1));
        for (int i = 0; i < 6; i++) cycle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
